// File: rtl/cpu5_instenc.sv
// cpu5 instruction encoder: turns structured commands into RV32I words for the
// decoder subset and queues them in a small FIFO for the fetch/inject path.
module cpu5_instenc #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_kind,
   input  logic [4:0]               cmd_rd,
   input  logic [4:0]               cmd_rs1,
   input  logic [4:0]               cmd_rs2,
   input  logic [11:0]              cmd_imm,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [31:0]              inst_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     illegal,
   output logic [7:0]               illegal_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [31:0]   NOP_WORD = 32'h0000_0013;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [2:0]    KIND_ILLEGAL = 3'd7;

   // Branch kinds take offset bits [12:1], so cmd_imm[11] is the sign (bit 12).
   function automatic logic [31:0] encode_cmd(
      input logic [2:0]  kind,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [11:0] imm
   );
      logic [31:0] word;
      word = NOP_WORD;
      case (kind)
         3'd0:    word = {imm, rs1, 3'b010, rd, 7'b0000011};
         3'd1:    word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
         3'd2:    word = {imm, rs1, 3'b000, rd, 7'b0010011};
         3'd3:    word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         3'd4:    word = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], 7'b1100011};
         3'd5:    word = {imm[11], imm[9:4], rs2, rs1, 3'b001, imm[3:0], imm[10], 7'b1100011};
         3'd6:    word = {imm, rs1, 3'b000, rd, 7'b1100111};
         default: word = NOP_WORD;
      endcase
      return word;
   endfunction

   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          illegal_q, illegal_d;
   logic [7:0]    illegal_cnt_q, illegal_cnt_d;

   logic          accept_s;
   logic          push_s;
   logic          pop_s;
   logic [31:0]   cmd_word_s;

   assign cmd_ready   = (level_q != LVL_FULL) & ~flush;
   assign accept_s    = cmd_valid & cmd_ready;
   assign push_s      = accept_s & (cmd_kind != KIND_ILLEGAL);
   assign inst_valid  = (level_q != '0);
   assign pop_s       = inst_valid & inst_ready;
   assign cmd_word_s  = encode_cmd(cmd_kind, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
   assign inst_data   = inst_valid ? mem_q[rd_ptr_q] : NOP_WORD;
   assign level       = level_q;
   assign illegal     = illegal_q;
   assign illegal_cnt = illegal_cnt_q;

   // Queue pointers, occupancy and illegal-command bookkeeping.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      illegal_d     = accept_s & (cmd_kind == KIND_ILLEGAL);
      illegal_cnt_d = illegal_cnt_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         level_d  = '0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
      if (illegal_d && (illegal_cnt_q != 8'hFF)) begin
         illegal_cnt_d = illegal_cnt_q + 8'd1;
      end else begin
         illegal_cnt_d = illegal_cnt_q;
      end
   end

   // Storage write; push is already suppressed while flush is high.
   always_comb begin
      mem_d = mem_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = cmd_word_s;
      end else begin
         mem_d = mem_q;
      end
   end

   // Control state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         illegal_q     <= 1'b0;
         illegal_cnt_q <= 8'd0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         illegal_q     <= illegal_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   // Entry storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_cpu5_instenc.sv
// Randomized and directed bench for cpu5_instenc against a queue-based
// reference model that encodes from the RV32I byte-offset view of each format.
module tb_cpu5_instenc;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, flush, cmd_valid, inst_ready;
   logic        cmd_ready, inst_valid, illegal;
   logic [2:0]  cmd_kind;
   logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
   logic [11:0] cmd_imm;
   logic [31:0] inst_data;
   logic [2:0]  level;
   logic [7:0]  illegal_cnt;

   int checks = 0;
   int failures = 0;

   logic [31:0] q_m [$];
   int          cnt_m = 0;
   logic        ill_m = 1'b0;

   always #5 clk = ~clk;

   cpu5_instenc #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .level(level), .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference encoder: branches are built from the real 13-bit byte offset.
   function automatic logic [31:0] ref_enc(input int kind, input int rd, input int rs1,
                                           input int rs2, input int imm);
      logic [31:0] op, f3, off, w;
      int ops [7] = '{3, 35, 19, 51, 99, 99, 103};
      int f3s [7] = '{2, 2, 0, 0, 0, 1, 0};
      op  = ops[kind];
      f3  = f3s[kind];
      off = imm * 2;
      case (kind)
         1:       w = ((imm / 32) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm % 32) << 7) | op;
         3:       w = (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
         4, 5:    w = (((off >> 12) & 1) << 31) | (((off >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                    | (f3 << 12) | (((off >> 1) & 15) << 8) | (((off >> 11) & 1) << 7) | op;
         default: w = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      endcase
      return w;
   endfunction

   task automatic drive(input bit v, input int kind, input int rd, input int rs1, input int rs2,
                        input int imm, input bit rdy, input bit fl);
      cmd_valid  = v;
      cmd_kind   = 3'(kind);
      cmd_rd     = 5'(rd);
      cmd_rs1    = 5'(rs1);
      cmd_rs2    = 5'(rs2);
      cmd_imm    = 12'(imm);
      inst_ready = rdy;
      flush      = fl;
   endtask

   // One clock: check outputs at the falling edge, then advance the model.
   task automatic cycle();
      bit exp_rdy, acc, pop;
      logic [31:0] w;
      @(negedge clk);
      exp_rdy = (q_m.size() != DEPTH) && !flush;
      check("level", 32'(level), 32'(q_m.size()));
      check("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
      check("inst_valid", 32'(inst_valid), 32'(q_m.size() != 0));
      check("inst_data", inst_data, (q_m.size() != 0) ? q_m[0] : 32'h0000_0013);
      check("illegal", 32'(illegal), 32'(ill_m));
      check("illegal_cnt", 32'(illegal_cnt), 32'(cnt_m));
      acc = cmd_valid && exp_rdy;
      pop = (q_m.size() != 0) && inst_ready;
      w   = ref_enc(cmd_kind, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
      @(posedge clk);
      ill_m = acc && (cmd_kind == 3'd7);
      if (ill_m && cnt_m < 255) cnt_m++;
      if (flush) begin
         q_m.delete();
      end else begin
         if (pop) void'(q_m.pop_front());
         if (acc && cmd_kind != 3'd7) q_m.push_back(w);
      end
      #1;
   endtask

   task automatic reset_model();
      q_m.delete();
      cnt_m = 0;
      ill_m = 1'b0;
   endtask

   initial begin
      int prev_cnt;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      check("rst_level", 32'(level), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_data", inst_data, 32'h0000_0013);
      check("rst_cnt", 32'(illegal_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cycle();

      // addi x1,x0,5
      drive(1, 2, 1, 0, 0, 5, 1, 0);
      cycle();
      check("addi_word", inst_data, 32'h0050_0093);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
      check("addi_drain", 32'(level), 32'd0);

      // sw x2,8(x3) then beq x1,x2,-8
      drive(1, 1, 9, 3, 2, 8, 0, 0);
      cycle();
      check("sw_word", inst_data, 32'h0021_A423);
      drive(1, 4, 7, 1, 2, 12'hFFC, 1, 0);
      cycle();
      check("beq_word", inst_data, 32'hFE20_8CE3);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      cycle();

      // Full queue, then a held fifth command
      for (int i = 0; i < 4; i++) begin
         drive(1, 3, 3, 1, 2, 0, 0, 0);
         cycle();
      end
      check("full_level", 32'(level), 32'd4);
      check("full_ready", 32'(cmd_ready), 32'd0);
      check("full_word", inst_data, 32'h0020_81B3);
      drive(1, 5, 0, 4, 5, 12'h123, 0, 0);
      cycle();
      cycle();
      drive(1, 5, 0, 4, 5, 12'h123, 1, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) cycle();

      // Simultaneous push/pop at level 2
      drive(1, 0, 5, 6, 0, 12'h7FF, 0, 0);
      cycle();
      cycle();
      drive(1, 6, 1, 2, 0, 12'h800, 1, 0);
      for (int i = 0; i < 10; i++) cycle();
      check("pushpop_level", 32'(level), 32'd2);

      // Single illegal command
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      prev_cnt = int'(illegal_cnt);
      drive(1, 7, 1, 1, 1, 1, 0, 0);
      cycle();
      check("ill_pulse", 32'(illegal), 32'd1);
      check("ill_cnt_inc", 32'(illegal_cnt), 32'(prev_cnt + 1));
      check("ill_level", 32'(level), 32'd2);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();

      // Flush at level 3 with a command offered
      drive(1, 2, 4, 4, 0, 99, 0, 0);
      cycle();
      drive(1, 2, 4, 4, 0, 77, 1, 1);
      cycle();
      check("flush_level", 32'(level), 32'd0);
      check("flush_data", inst_data, 32'h0000_0013);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();

      // Asynchronous reset mid-burst
      drive(1, 3, 2, 3, 4, 0, 0, 0);
      cycle();
      cycle();
      #2;
      reset = 1'b1;
      #1;
      reset_model();
      check("arst_level", 32'(level), 32'd0);
      check("arst_valid", 32'(inst_valid), 32'd0);
      check("arst_data", inst_data, 32'h0000_0013);
      check("arst_cnt", 32'(illegal_cnt), 32'd0);
      reset = 1'b0;
      drive(1, 2, 1, 0, 0, 5, 0, 0);
      cycle();
      check("post_rst_word", inst_data, 32'h0050_0093);

      // Illegal count saturation
      drive(1, 7, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 300; i++) cycle();
      check("ill_sat", 32'(illegal_cnt), 32'd255);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 4) != 0, ((($urandom % 8) == 0) ? 7 : int'($urandom % 7)),
               int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
               int'($urandom % 4096), (i % 400 < 200) ? (($urandom % 4) == 0) : (($urandom % 3) != 0),
               ($urandom % 40) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu5_instenc.md
# cpu5_instenc

Instruction encoder and issue queue for the cpu5 core. Accepts structured instruction commands (kind, register fields, immediate) over a valid/ready handshake, encodes them into 32-bit RV32I machine words for the subset the cpu5 main decoder executes (lw, sw, addi, add, beq, bne, jalr), and buffers them in a small FIFO. The FIFO issues words to the fetch/inject path over a second valid/ready handshake. It is used by the debug/self-test injector to feed the core without a program ROM.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous queue clear.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_kind  in  3  0 lw, 1 sw, 2 addi, 3 add, 4 beq, 5 bne, 6 jalr, 7 illegal.
- cmd_rd  in  5  destination register.
- cmd_rs1  in  5  source register 1.
- cmd_rs2  in  5  source register 2.
- cmd_imm  in  12  imm[11:0] for I/S kinds; branch offset bits [12:1] for beq/bne.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  consumer takes the head.
- inst_data  out  32  encoded word at the queue head.
- level  out  $clog2(DEPTH)+1  current occupancy.
- illegal  out  1  one-cycle pulse, registered, when a kind-7 command is accepted.
- illegal_cnt  out  8  saturating count of illegal commands.

## Operation

- Command accept: cmd_valid & cmd_ready at a rising edge.
- cmd_ready = (level != DEPTH) & ~flush. It does not account for a same-cycle pop; a full queue refuses the command even when inst_ready is high.
- Encoding (opcode / funct3):
  - lw: I-type, 0000011 / 010.
  - sw: S-type, 0100011 / 010.
  - addi: I-type, 0010011 / 000.
  - add: R-type, 0110011 / 000, funct7 0000000.
  - beq: B-type, 1100011 / 000.
  - bne: B-type, 1100011 / 001.
  - jalr: I-type, 1100111 / 000.
- Field placement:
  - I-type: {imm[11:0], rs1, f3, rd, op}.
  - S-type: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - R-type: {f7, rs2, rs1, f3, rd, op}.
  - B-type, with o = cmd_imm: {o[11], o[9:4], rs2, rs1, f3, o[3:0], o[10], op}.
- Fields not used by a kind are ignored: rd for sw/beq/bne, rs2 for I-types, imm for add.
- Kind 7 is accepted (it consumes the handshake) but is not enqueued. It raises illegal for one cycle and increments illegal_cnt, which saturates at 255.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - level is the count register.
  - A push (legal accept) and a pop (inst_valid & inst_ready) in the same cycle leave level unchanged.
  - Words issue in acceptance order.
- inst_valid = (level != 0).
- inst_data = mem[rd_ptr] when inst_valid is high, else 32'h00000013 (NOP).
- flush: next edge sets level to 0 and equalizes the pointers. It overrides any same-cycle push and pop. illegal_cnt is not cleared by flush.
- reset: immediately sets level 0, pointers 0, illegal 0, illegal_cnt 0. FIFO storage need not be reset.

## Timing

- Reset values: cmd_ready 1, inst_valid 0, inst_data 32'h00000013, level 0, illegal 0, illegal_cnt 0.
- Latency: a command accepted at edge N appears on inst_data with inst_valid high after edge N (visible in cycle N+1) if the queue was empty. There is no combinational path from cmd_* to inst_*.
- Throughput: one accept and one issue per cycle while 0 < level < DEPTH.
- illegal is high for exactly the cycle after the accepting edge. illegal_cnt updates at that same edge.
- Reset asserted mid-operation discards all queued words. After deassertion, the first edge with a valid command behaves as from empty.

## Test plan

- addi x1,x0,5: kind 2, rd 1, rs1 0, imm 5, inst_ready 1 -> next cycle inst_valid 1, inst_data 0x00500093; level returns to 0 after pop.
- sw x2,8(x3) then beq x1,x2,-8: first command rs1 3, rs2 2, imm 8; second cmd_imm 0xFFC -> inst_data 0x0021A423 then 0xFE208CE3.
- Full queue: inst_ready 0, push four copies of add x3,x1,x2 -> each word 0x002081B3, level 4, cmd_ready 0. A fifth command is held until inst_ready 1, then accepted; five words drain in order with no loss.
- Simultaneous push/pop at level 2 -> level stays 2; pointer wrap exercised across more than 8 pushes with order preserved.
- Kind 7 -> level unchanged, illegal pulse of 1 cycle, illegal_cnt +1. After 300 kind-7 commands, illegal_cnt = 255.
- Flush at level 3 with cmd_valid high -> next cycle level 0, inst_valid 0, inst_data 0x00000013, command not enqueued. Asynchronous reset mid-burst -> outputs at reset values immediately.
